// File: rtl/mips_encoder_if.sv
// Request channel into the MIPS instruction encoder.
// The master drives one request; the slave raises in_ready when it can take it.
interface mips_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_op;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;
  logic [4:0]  in_shamt;
  logic [25:0] in_imm;
  logic        in_last;

  modport master (
    output in_valid, in_op, in_rs, in_rt,
    output in_rd, in_shamt, in_imm, in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_op, in_rs, in_rt,
    input  in_rd, in_shamt, in_imm, in_last,
    output in_ready
  );
endinterface

// File: rtl/mips_encoder.sv
// Encodes op-indexed requests into MIPS32 words and writes them to instruction memory.
// Define MIPS_ENC_MEMBYTE_EN to enable the lb/lbu/sb encodings (ops 36-38).
module mips_encoder #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  mips_encoder_if.slave     req,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              done,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err,
  output logic [5:0]        err_op
);
  typedef enum logic [1:0] {IDLE, ENC, WR, DONE} state_t;
  typedef enum logic [1:0] {F_NONE, F_R, F_I, F_J} fmt_t;

  localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);

  state_t      state, nxt;
  logic [5:0]  op;
  logic [4:0]  rs, rt, rd, sh;
  logic [25:0] imm;
  logic        last;
  fmt_t        fmt;
  logic [5:0]  code;
  logic [4:0]  rs_e, rt_e, rd_e, sh_e;
  logic [31:0] word;
  logic        ok;
  logic        accept;
  logic [ADDR_W:0] cnt_n;

  assign req.in_ready = (state == IDLE) && !full;
  assign accept = req.in_valid && req.in_ready;
  assign cnt_n = count + ONE;
  assign ok = (fmt != F_NONE);

  always_comb begin
    fmt  = F_R;
    code = '0;
    rs_e = rs;
    rt_e = rt;
    rd_e = rd;
    sh_e = '0;
    word = '0;
    case (op)
      6'd0:  code = 6'h20;
      6'd1:  code = 6'h21;
      6'd2:  code = 6'h22;
      6'd3:  code = 6'h23;
      6'd4:  code = 6'h24;
      6'd5:  code = 6'h25;
      6'd6:  code = 6'h26;
      6'd7:  code = 6'h27;
      6'd8:  code = 6'h2a;
      6'd9:  code = 6'h2b;
      6'd10: begin code = 6'h00; rs_e = '0; sh_e = sh; end
      6'd11: begin code = 6'h02; rs_e = '0; sh_e = sh; end
      6'd12: begin code = 6'h03; rs_e = '0; sh_e = sh; end
      6'd13: code = 6'h04;
      6'd14: code = 6'h06;
      6'd15: code = 6'h07;
      6'd16: begin code = 6'h08; rt_e = '0; rd_e = '0; end
      6'd17: begin code = 6'h09; rt_e = '0; end
      6'd18: begin fmt = F_I; code = 6'h08; end
      6'd19: begin fmt = F_I; code = 6'h09; end
      6'd20: begin fmt = F_I; code = 6'h0a; end
      6'd21: begin fmt = F_I; code = 6'h0b; end
      6'd22: begin fmt = F_I; code = 6'h0c; end
      6'd23: begin fmt = F_I; code = 6'h0d; end
      6'd24: begin fmt = F_I; code = 6'h0e; end
      6'd25: begin fmt = F_I; code = 6'h0f; rs_e = '0; end
      6'd26: begin fmt = F_I; code = 6'h23; end
      6'd27: begin fmt = F_I; code = 6'h2b; end
      6'd28: begin fmt = F_I; code = 6'h04; end
      6'd29: begin fmt = F_I; code = 6'h05; end
      // REGIMM branches select bgez/bltz through the rt field
      6'd30: begin fmt = F_I; code = 6'h01; rt_e = 5'd1; end
      6'd31: begin fmt = F_I; code = 6'h01; rt_e = '0; end
      6'd32: begin fmt = F_I; code = 6'h07; rt_e = '0; end
      6'd33: begin fmt = F_I; code = 6'h06; rt_e = '0; end
      6'd34: begin fmt = F_J; code = 6'h02; end
      6'd35: begin fmt = F_J; code = 6'h03; end
`ifdef MIPS_ENC_MEMBYTE_EN
      6'd36: begin fmt = F_I; code = 6'h20; end
      6'd37: begin fmt = F_I; code = 6'h24; end
      6'd38: begin fmt = F_I; code = 6'h28; end
`endif
      default: fmt = F_NONE;
    endcase
    case (fmt)
      F_R:     word = {6'd0, rs_e, rt_e, rd_e, sh_e, code};
      F_I:     word = {code, rs_e, rt_e, imm[15:0]};
      F_J:     word = {code, imm};
      default: word = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    if (clr) begin
      nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: if (accept) nxt = ENC;
        ENC:  nxt = ok ? WR : (last ? DONE : IDLE);
        WR:   nxt = last ? DONE : IDLE;
        DONE: nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op       <= '0;
      rs       <= '0;
      rt       <= '0;
      rd       <= '0;
      sh       <= '0;
      imm      <= '0;
      last     <= 1'b0;
      im_we    <= 1'b0;
      im_addr  <= '0;
      im_wdata <= '0;
      done     <= 1'b0;
      count    <= '0;
      full     <= 1'b0;
      err      <= 1'b0;
      err_op   <= '0;
    end else begin
      im_we <= 1'b0;
      done  <= 1'b0;
      if (clr) begin
        count  <= '0;
        full   <= 1'b0;
        err    <= 1'b0;
        err_op <= '0;
      end else begin
        if (accept) begin
          op   <= req.in_op;
          rs   <= req.in_rs;
          rt   <= req.in_rt;
          rd   <= req.in_rd;
          sh   <= req.in_shamt;
          imm  <= req.in_imm;
          last <= req.in_last;
        end
        if (state == ENC) begin
          if (ok) begin
            im_wdata <= word;
          end else begin
            err <= 1'b1;
            if (!err) err_op <= op;
          end
        end
        // count saturates at DEPTH, whose top bit is the full flag
        if (state == WR) begin
          im_we   <= 1'b1;
          im_addr <= count[ADDR_W-1:0];
          count   <= cnt_n;
          full    <= cnt_n[ADDR_W];
        end
        if (state == DONE) done <= 1'b1;
      end
    end
  end
endmodule

// File: doc/mips_encoder.md
MIPS_ENCODER -- requirements
Module: mips_encoder

Interface
REQ-001 SHALL have parameter: ADDR_W, 10, instruction-memory word-address width; DEPTH = 2^ADDR_W words.
REQ-002 SHALL have ports (name direction width meaning):
 clk  in  1  clock; one clock, all logic on rising edge.
 rst  in  1  reset; synchronous, active-high.
 clr  in  1  synchronous clear of address, count, full and error state.
 in_valid  in  1  instruction request valid.
 in_ready  out  1  encoder can accept a request.
 in_op  in  6  operation index (REQ-008).
 in_rs, in_rt, in_rd, in_shamt  in  5 each  register and shift fields.
 in_imm  in  26  imm16 in [15:0], J-target in [25:0].
 in_last  in  1  marks the final instruction of a program.
 im_we  out  1  instruction-memory write strobe.
 im_addr  out  ADDR_W  word address of the write.
 im_wdata  out  32  encoded instruction word.
 done  out  1  one-cycle pulse after the last instruction completes.
 count  out  ADDR_W+1  number of words written.
 full  out  1  DEPTH words written.
 err  out  1  sticky flag: unsupported op seen.
 err_op  out  6  in_op of the first unsupported request.

Function
REQ-003 FSM states SHALL be IDLE, ENC, WR and DONE; in_ready SHALL equal (state==IDLE && !full).
REQ-004 Handshake: in_valid&&in_ready in IDLE SHALL latch all in_* fields and go to ENC; in_valid without in_ready SHALL be ignored, with no back-pressure storage.
REQ-005 ENC SHALL register the 32-bit word and go to WR; for an unsupported op it SHALL set err, capture err_op only if err was 0, write nothing, and go to DONE if the request was last, else IDLE.
REQ-006 WR SHALL assert im_we=1 for exactly one cycle with im_addr=count[ADDR_W-1:0]; count SHALL increment at the end of WR; next state SHALL be DONE if the request was last, else IDLE.
REQ-007 DONE SHALL assert done=1 for one cycle, then go to IDLE; count is not cleared by done.
REQ-008 in_op mapping, with standard MIPS32 opcode and funct values:
 0-15: add, addu, sub, subu, and, or, xor, nor, slt, sltu, sll, srl, sra, sllv, srlv, srav.
 16-17: jr, jalr. 18-25: addi, addiu, slti, sltiu, andi, ori, xori, lui.
 26-27: lw, sw. 28-29: beq, bne. 30-33: bgez, bltz, bgtz, blez.
 34-35: j, jal. 36-38: lb, lbu, sb. 39-63: unsupported.
REQ-009 R-type SHALL encode {000000,rs,rt,rd,shamt,funct}:
 shamt forced 0 except sll/srl/sra.
 rs forced 0 for sll/srl/sra.
 jr: rt, rd and shamt forced 0; jalr: rt and shamt forced 0.
REQ-010 I-type SHALL encode {op,rs,rt,imm[15:0]}:
 lui rs=0; bgtz/blez rt=0.
 bgez and bltz use op 000001 with rt=00001 and rt=00000 respectively.
REQ-011 j and jal SHALL encode {op,imm[25:0]}.
REQ-012 full SHALL go to 1 when count reaches DEPTH; the address SHALL never wrap; in_ready stays 0 until clr or rst.
REQ-013 clr SHALL have lower priority than rst, act in any state, abort any in-flight request with no im_we, zero count/full/err/err_op, and return to IDLE.

Reset
REQ-014 rst SHALL force state IDLE and zero im_we, im_addr, im_wdata, done, count, full, err and err_op; in_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-015 With MIPS_ENC_MEMBYTE_EN defined, in_op 36-38 SHALL encode lb/lbu/sb (op 0x20/0x24/0x28); without it they SHALL be treated as unsupported per REQ-005.

Verification
REQ-016 addi, rs=1 rt=2 imm=0xFFFF, at count 0 -> im_we on the 3rd cycle after accept, im_addr=0, im_wdata=0x2022FFFF, count=1.
REQ-017 add rs=1 rt=2 rd=3, then sll rt=2 rd=3 shamt=4 with in_rs=7 and in_last=1 -> writes 0x00221820 then 0x00021900; done pulses one cycle after the second write.
REQ-018 bgez rs=5 imm=0x0010 -> 0x04A10010; j imm=0x0000040 -> 0x08000040.
REQ-019 in_op=50, then in_op=45 -> no im_we, err=1, err_op=50, count unchanged; clr -> err=0, err_op=0.
REQ-020 ADDR_W=2, four writes -> full=1, in_ready=0, fifth in_valid ignored; clr asserted during WR -> no im_we, count=0.
